// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gray_pkg
// Brief    : Shared constants and Gray/binary helper functions for the Gray
//            count receiver. Functions work on GRAY_MAX_W-bit words; callers
//            zero-extend narrower values and truncate the result.
// Revision : 1.0 - initial release
// ============================================================================
package gray_pkg;

  // Widest counter the helpers support.
  localparam int GRAY_MAX_W    = 64;
  // Smallest synchronizer depth that gives metastability protection.
  localparam int GRAY_SYNC_MIN = 2;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary to Gray.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Number of set bits.
  function automatic int unsigned popcount(input logic [GRAY_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray_sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : gray_sync_chain
// Brief    : Multi-flop synchronizer for a Gray-coded word crossing into CLK.
//            SYNC_STAGES must be at least gray_pkg::GRAY_SYNC_MIN (2..4).
// Revision : 1.0 - initial release
// ============================================================================
module gray_sync_chain #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] GRAY_I,
  output logic [WIDTH-1:0] GSYNC_O
);

  // Stage 0 is the only flop that sees the foreign-domain word.
  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE", SHREG_EXTRACT = "NO" *)
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;

  // Shift the chain by one stage, new word entering at stage 0.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = GRAY_I;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Chain registers; asynchronous clear so Gray(0) is seen right after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign GSYNC_O = sync_q[SYNC_STAGES-1];

endmodule : gray_sync_chain
`default_nettype wire

// File: rtl/gray_count_receiver.sv
`default_nettype none
// ============================================================================
// Module   : gray_count_receiver
// Brief    : Synchronizes a foreign-domain Gray counter, converts it to
//            binary, reports the increment since the last update and, when
//            GRAY_RX_ERR_CHECK_EN is defined, flags multi-bit Gray steps.
// Revision : 1.0 - initial release
// ============================================================================
module gray_count_receiver
  import gray_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] GRAY_I,
  input  logic             CLR,
  output logic [WIDTH-1:0] BIN_O,
  output logic [WIDTH-1:0] DELTA_O,
  output logic             UPDATE_O,
  output logic             ERR_O
);

  logic [WIDTH-1:0] gsync;
  logic [WIDTH-1:0] conv;
  logic [WIDTH-1:0] bin_q,   bin_d;
  logic [WIDTH-1:0] delta_q, delta_d;
  logic             update_q, update_d;

  gray_sync_chain #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK     (CLK),
    .RST     (RST),
    .GRAY_I  (GRAY_I),
    .GSYNC_O (gsync)
  );

  // Convert the synchronized word and derive update pulse and delta.
  // An update overrides a coincident CLR so no increment is ever lost.
  always_comb begin
    conv     = WIDTH'(gray2bin(GRAY_MAX_W'(gsync)));
    bin_d    = conv;
    update_d = (conv != bin_q);
    delta_d  = delta_q;
    if (CLR) begin
      delta_d = '0;
    end
    if (update_d) begin
      delta_d = conv - bin_q;
    end
  end

  // Output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bin_q    <= '0;
      delta_q  <= '0;
      update_q <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      delta_q  <= delta_d;
      update_q <= update_d;
    end
  end

  assign BIN_O    = bin_q;
  assign DELTA_O  = delta_q;
  assign UPDATE_O = update_q;

`ifdef GRAY_RX_ERR_CHECK_EN
  logic [WIDTH-1:0] gprev_q, gprev_d;
  logic             err_q,   err_d;

  // Sticky error: a legal Gray step flips at most one bit; set beats CLR.
  always_comb begin
    gprev_d = gsync;
    err_d   = err_q;
    if (CLR) begin
      err_d = 1'b0;
    end
    if (popcount(GRAY_MAX_W'(gsync ^ gprev_q)) > 1) begin
      err_d = 1'b1;
    end
  end

  // Previous synchronized word and error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gprev_q <= '0;
      err_q   <= 1'b0;
    end else begin
      gprev_q <= gprev_d;
      err_q   <= err_d;
    end
  end

  assign ERR_O = err_q;
`else
  assign ERR_O = 1'b0;
`endif

endmodule : gray_count_receiver
`default_nettype wire
